uart_frame_check: RTL and testbench

UART_FRAME_CHECK -- requirements
Module: uart_frame_check

---
 rtl/uart_frame_check.sv | 255 +++++++++++++++++++++++++
 tb/tb_uart_frame_check.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_check.sv
// UART frame checker: takes majority-voted bits from the receiver front end,
// assembles one frame (start, data, optional parity, stop bits) and reports
// a good word or the error found. Keeps saturating parity/stop error counts.
module uart_frame_check #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  frame_start,
    input  logic                  bit_valid,
    input  logic                  sampled_bit,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  clr_cnt,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  start_error,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stop_err_cnt
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0]       BIT_LAST = BCW'(DATA_WIDTH - 1);
    localparam logic [BCW-1:0]       BIT_MAX  = BCW'(DATA_WIDTH);
    localparam logic [BCW-1:0]       BIT_ONE  = BCW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam bit                   TWO_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // Expected parity bit of a data word; odd=1 selects odd parity.
    function automatic logic f_exp_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    state_t                r_state, w_state_nxt;
    logic                  r_par_en, w_par_en_nxt;
    logic                  r_par_typ, w_par_typ_nxt;
    logic [BCW-1:0]        r_bit_cnt, w_bit_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_shadow, w_shadow_nxt;
    logic                  r_par_flag, w_par_flag_nxt;
    logic                  r_stop_flag, w_stop_flag_nxt;
    logic [DATA_WIDTH-1:0] r_data_out, w_data_out_nxt;
    logic                  r_data_valid, w_data_valid_nxt;
    logic                  r_start_err, w_start_err_nxt;
    logic                  r_par_err, w_par_err_nxt;
    logic                  r_stop_err, w_stop_err_nxt;
    logic                  r_busy, w_busy_nxt;
    logic [CNT_WIDTH-1:0]  r_par_cnt, w_par_cnt_nxt;
    logic [CNT_WIDTH-1:0]  r_stop_cnt, w_stop_cnt_nxt;
    logic                  w_finish;

    // State register; reset returns to IDLE from anywhere.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, frame datapath and next values of every registered output.
    always_comb begin
        w_state_nxt      = r_state;
        w_par_en_nxt     = r_par_en;
        w_par_typ_nxt    = r_par_typ;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_shadow_nxt     = r_shadow;
        w_par_flag_nxt   = r_par_flag;
        w_stop_flag_nxt  = r_stop_flag;
        w_data_out_nxt   = r_data_out;
        w_data_valid_nxt = 1'b0;
        w_start_err_nxt  = 1'b0;
        w_par_err_nxt    = 1'b0;
        w_stop_err_nxt   = 1'b0;
        w_par_cnt_nxt    = r_par_cnt;
        w_stop_cnt_nxt   = r_stop_cnt;
        w_finish         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    // Parity configuration is frozen for the whole frame.
                    w_state_nxt     = S_START;
                    w_par_en_nxt    = PAR_EN;
                    w_par_typ_nxt   = PAR_TYP;
                    w_par_flag_nxt  = 1'b0;
                    w_stop_flag_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (bit_valid) begin
                    if (sampled_bit) begin
                        // False start: abort quietly apart from start_error.
                        w_state_nxt     = S_IDLE;
                        w_start_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = S_DATA;
                        w_bit_cnt_nxt = {BCW{1'b0}};
                    end
                end else begin
                    w_state_nxt = S_START;
                end
            end
            S_DATA: begin
                if (bit_valid) begin
                    w_shadow_nxt = {sampled_bit, r_shadow[DATA_WIDTH-1:1]};
                    if (r_bit_cnt != BIT_MAX) begin
                        w_bit_cnt_nxt = r_bit_cnt + BIT_ONE;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt;
                    end
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_nxt = r_par_en ? S_PARITY : S_STOP1;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_PARITY: begin
                if (bit_valid) begin
                    w_state_nxt = S_STOP1;
                    if (sampled_bit != f_exp_parity(r_shadow, r_par_typ)) begin
                        w_par_flag_nxt = 1'b1;
                    end else begin
                        w_par_flag_nxt = r_par_flag;
                    end
                end else begin
                    w_state_nxt = S_PARITY;
                end
            end
            S_STOP1: begin
                if (bit_valid) begin
                    w_stop_flag_nxt = r_stop_flag | ~sampled_bit;
                    if (TWO_STOP) begin
                        w_state_nxt = S_STOP2;
                    end else begin
                        w_state_nxt = S_DONE;
                        w_finish    = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_STOP1;
                end
            end
            S_STOP2: begin
                if (bit_valid) begin
                    w_stop_flag_nxt = r_stop_flag | ~sampled_bit;
                    w_state_nxt     = S_DONE;
                    w_finish        = 1'b1;
                end else begin
                    w_state_nxt = S_STOP2;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Result pulses are loaded on the edge that enters DONE so they are
        // visible during the DONE cycle, one cycle after the last stop bit.
        if (w_finish) begin
            w_par_err_nxt    = r_par_flag;
            w_stop_err_nxt   = w_stop_flag_nxt;
            w_data_valid_nxt = ~(r_par_flag | w_stop_flag_nxt);
            w_data_out_nxt   = r_shadow;
        end else begin
            w_data_out_nxt = r_data_out;
        end

        // Counters follow the registered pulses; clear beats increment.
        if (clr_cnt) begin
            w_par_cnt_nxt  = {CNT_WIDTH{1'b0}};
            w_stop_cnt_nxt = {CNT_WIDTH{1'b0}};
        end else begin
            if (r_par_err && (r_par_cnt != CNT_MAX)) begin
                w_par_cnt_nxt = r_par_cnt + CNT_ONE;
            end else begin
                w_par_cnt_nxt = r_par_cnt;
            end
            if (r_stop_err && (r_stop_cnt != CNT_MAX)) begin
                w_stop_cnt_nxt = r_stop_cnt + CNT_ONE;
            end else begin
                w_stop_cnt_nxt = r_stop_cnt;
            end
        end

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // Datapath and output registers, all cleared by reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_bit_cnt    <= {BCW{1'b0}};
            r_shadow     <= {DATA_WIDTH{1'b0}};
            r_par_flag   <= 1'b0;
            r_stop_flag  <= 1'b0;
            r_data_out   <= {DATA_WIDTH{1'b0}};
            r_data_valid <= 1'b0;
            r_start_err  <= 1'b0;
            r_par_err    <= 1'b0;
            r_stop_err   <= 1'b0;
            r_busy       <= 1'b0;
            r_par_cnt    <= {CNT_WIDTH{1'b0}};
            r_stop_cnt   <= {CNT_WIDTH{1'b0}};
        end else begin
            r_par_en     <= w_par_en_nxt;
            r_par_typ    <= w_par_typ_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shadow     <= w_shadow_nxt;
            r_par_flag   <= w_par_flag_nxt;
            r_stop_flag  <= w_stop_flag_nxt;
            r_data_out   <= w_data_out_nxt;
            r_data_valid <= w_data_valid_nxt;
            r_start_err  <= w_start_err_nxt;
            r_par_err    <= w_par_err_nxt;
            r_stop_err   <= w_stop_err_nxt;
            r_busy       <= w_busy_nxt;
            r_par_cnt    <= w_par_cnt_nxt;
            r_stop_cnt   <= w_stop_cnt_nxt;
        end
    end

    assign data_out     = r_data_out;
    assign data_valid   = r_data_valid;
    assign start_error  = r_start_err;
    assign parity_error = r_par_err;
    assign stop_error   = r_stop_err;
    assign busy         = r_busy;
    assign par_err_cnt  = r_par_cnt;
    assign stop_err_cnt = r_stop_cnt;

endmodule

// File: tb/tb_uart_frame_check.sv
// Directed bench for uart_frame_check. Two instances share the stimulus:
// u_b (two stop bits, 2-bit counters) carries most checks, u_a (one stop
// bit, 8-bit counters) finishes one bit earlier on the same frames.
module tb_uart_frame_check;

    logic CLK = 1'b0;
    logic Reset, frame_start, bit_valid, sampled_bit, PAR_EN, PAR_TYP, clr_cnt;

    logic [7:0] a_data_out, a_par_cnt, a_stop_cnt;
    logic       a_data_valid, a_start_error, a_parity_error, a_stop_error, a_busy;
    logic [7:0] b_data_out;
    logic [1:0] b_par_cnt, b_stop_cnt;
    logic       b_data_valid, b_start_error, b_parity_error, b_stop_error, b_busy;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    uart_frame_check #(.DATA_WIDTH(8), .STOP_BITS(1), .CNT_WIDTH(8)) u_a (
        .CLK(CLK), .Reset(Reset), .frame_start(frame_start), .bit_valid(bit_valid),
        .sampled_bit(sampled_bit), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .clr_cnt(clr_cnt),
        .data_out(a_data_out), .data_valid(a_data_valid), .start_error(a_start_error),
        .parity_error(a_parity_error), .stop_error(a_stop_error), .busy(a_busy),
        .par_err_cnt(a_par_cnt), .stop_err_cnt(a_stop_cnt));

    uart_frame_check #(.DATA_WIDTH(8), .STOP_BITS(2), .CNT_WIDTH(2)) u_b (
        .CLK(CLK), .Reset(Reset), .frame_start(frame_start), .bit_valid(bit_valid),
        .sampled_bit(sampled_bit), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .clr_cnt(clr_cnt),
        .data_out(b_data_out), .data_valid(b_data_valid), .start_error(b_start_error),
        .parity_error(b_parity_error), .stop_error(b_stop_error), .busy(b_busy),
        .par_err_cnt(b_par_cnt), .stop_err_cnt(b_stop_cnt));

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_frame(input logic pe, input logic pt);
        PAR_EN = pe;
        PAR_TYP = pt;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        sampled_bit = b;
        tick();
        bit_valid = 1'b0;
        sampled_bit = 1'b1;
    endtask

    task automatic send_data(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) tick();
        checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", b_busy); end
        checks++; if (b_data_out !== 8'h00) begin failures++; $display("FAIL rst_data: got %h want 00", b_data_out); end
        checks++; if ({b_data_valid, b_start_error, b_parity_error, b_stop_error} !== 4'b0000) begin failures++; $display("FAIL rst_pulses: got %b want 0000", {b_data_valid, b_start_error, b_parity_error, b_stop_error}); end
        checks++; if ({b_par_cnt, b_stop_cnt} !== 4'h0) begin failures++; $display("FAIL rst_cnt: got %h want 0", {b_par_cnt, b_stop_cnt}); end
        checks++; if ({a_busy, a_par_cnt, a_stop_cnt} !== 17'h0) begin failures++; $display("FAIL rst_a: got %h want 0", {a_busy, a_par_cnt, a_stop_cnt}); end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_good_frame();
        start_frame(1'b1, 1'b0);
        checks++; if (b_busy !== 1'b1) begin failures++; $display("FAIL good_busy: got %b want 1", b_busy); end
        send_bit(1'b0);
        send_data(8'h55);
        send_bit(1'b0);
        send_bit(1'b1);
        checks++; if (a_data_valid !== 1'b1 || a_data_out !== 8'h55) begin failures++; $display("FAIL good_a: got v=%b d=%h want v=1 d=55", a_data_valid, a_data_out); end
        checks++; if (b_data_valid !== 1'b0 || b_busy !== 1'b1) begin failures++; $display("FAIL good_b_early: got v=%b busy=%b want v=0 busy=1", b_data_valid, b_busy); end
        send_bit(1'b1);
        checks++; if (b_data_valid !== 1'b1) begin failures++; $display("FAIL good_valid: got %b want 1", b_data_valid); end
        checks++; if (b_data_out !== 8'h55) begin failures++; $display("FAIL good_data: got %h want 55", b_data_out); end
        checks++; if ({b_start_error, b_parity_error, b_stop_error} !== 3'b000) begin failures++; $display("FAIL good_errs: got %b want 000", {b_start_error, b_parity_error, b_stop_error}); end
        tick();
        checks++; if (b_data_valid !== 1'b0 || b_busy !== 1'b0) begin failures++; $display("FAIL good_after: got v=%b busy=%b want 0 0", b_data_valid, b_busy); end
        checks++; if ({b_par_cnt, b_stop_cnt} !== 4'h0) begin failures++; $display("FAIL good_cnt: got %h want 0", {b_par_cnt, b_stop_cnt}); end
    endtask

    task automatic test_parity_error();
        start_frame(1'b1, 1'b0);
        send_bit(1'b0);
        send_data(8'h55);
        send_bit(1'b1);
        send_bit(1'b1);
        checks++; if (a_parity_error !== 1'b1) begin failures++; $display("FAIL par_a: got %b want 1", a_parity_error); end
        send_bit(1'b1);
        checks++; if (b_parity_error !== 1'b1 || b_data_valid !== 1'b0) begin failures++; $display("FAIL par_pulse: got pe=%b v=%b want pe=1 v=0", b_parity_error, b_data_valid); end
        checks++; if (b_data_out !== 8'h55 || b_stop_error !== 1'b0) begin failures++; $display("FAIL par_data: got d=%h se=%b want d=55 se=0", b_data_out, b_stop_error); end
        tick();
        checks++; if (b_par_cnt !== 2'd1 || b_stop_cnt !== 2'd0) begin failures++; $display("FAIL par_cnt: got p=%0d s=%0d want p=1 s=0", b_par_cnt, b_stop_cnt); end
    endtask

    task automatic test_odd_parity();
        // PAR_TYP flips after acceptance; the latched odd setting must hold.
        start_frame(1'b1, 1'b1);
        PAR_TYP = 1'b0;
        PAR_EN = 1'b0;
        send_bit(1'b0);
        send_data(8'h07);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        checks++; if (b_data_valid !== 1'b1 || b_parity_error !== 1'b0) begin failures++; $display("FAIL odd_valid: got v=%b pe=%b want v=1 pe=0", b_data_valid, b_parity_error); end
        checks++; if (b_data_out !== 8'h07) begin failures++; $display("FAIL odd_data: got %h want 07", b_data_out); end
        tick();
        checks++; if (b_par_cnt !== 2'd1) begin failures++; $display("FAIL odd_cnt: got %0d want 1", b_par_cnt); end
    endtask

    task automatic test_stop_error();
        start_frame(1'b0, 1'b0);
        send_bit(1'b0);
        send_data(8'hA3);
        send_bit(1'b1);
        checks++; if (b_stop_error !== 1'b0 || b_data_valid !== 1'b0) begin failures++; $display("FAIL stop_early: got se=%b v=%b want 0 0", b_stop_error, b_data_valid); end
        checks++; if (a_data_valid !== 1'b1 || a_data_out !== 8'hA3 || a_stop_error !== 1'b0) begin failures++; $display("FAIL stop_a: got v=%b d=%h se=%b want 1 a3 0", a_data_valid, a_data_out, a_stop_error); end
        send_bit(1'b0);
        checks++; if (b_stop_error !== 1'b1 || b_data_valid !== 1'b0) begin failures++; $display("FAIL stop_pulse: got se=%b v=%b want se=1 v=0", b_stop_error, b_data_valid); end
        checks++; if (b_data_out !== 8'hA3 || b_parity_error !== 1'b0) begin failures++; $display("FAIL stop_data: got d=%h pe=%b want d=a3 pe=0", b_data_out, b_parity_error); end
        tick();
        checks++; if (b_stop_cnt !== 2'd1 || b_stop_error !== 1'b0) begin failures++; $display("FAIL stop_cnt: got cnt=%0d se=%b want 1 0", b_stop_cnt, b_stop_error); end
    endtask

    task automatic test_start_error();
        logic [7:0] d;
        d = 8'h3C;
        send_bit(1'b0);
        send_bit(1'b1);
        checks++; if (b_busy !== 1'b0 || b_data_valid !== 1'b0) begin failures++; $display("FAIL idle_bits: got busy=%b v=%b want 0 0", b_busy, b_data_valid); end
        start_frame(1'b0, 1'b0);
        send_bit(1'b1);
        checks++; if (b_start_error !== 1'b1 || a_start_error !== 1'b1) begin failures++; $display("FAIL start_pulse: got b=%b a=%b want 1 1", b_start_error, a_start_error); end
        checks++; if (b_busy !== 1'b0 || {b_data_valid, b_parity_error, b_stop_error} !== 3'b000) begin failures++; $display("FAIL start_other: got busy=%b pulses=%b want 0 000", b_busy, {b_data_valid, b_parity_error, b_stop_error}); end
        tick();
        checks++; if (b_start_error !== 1'b0) begin failures++; $display("FAIL start_len: got %b want 0", b_start_error); end
        start_frame(1'b0, 1'b0);
        checks++; if (b_busy !== 1'b1) begin failures++; $display("FAIL restart_busy: got %b want 1", b_busy); end
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 4; i < 8; i++) send_bit(d[i]);
        send_bit(1'b1);
        send_bit(1'b1);
        checks++; if (b_data_valid !== 1'b1 || b_data_out !== 8'h3C) begin failures++; $display("FAIL restart_data: got v=%b d=%h want 1 3c", b_data_valid, b_data_out); end
        tick();
    endtask

    task automatic stop_err_frame();
        start_frame(1'b0, 1'b0);
        send_bit(1'b0);
        send_data(8'hA3);
        send_bit(1'b1);
        send_bit(1'b0);
    endtask

    task automatic test_saturation();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checks++; if (b_par_cnt !== 2'd0 || b_stop_cnt !== 2'd0) begin failures++; $display("FAIL clr: got p=%0d s=%0d want 0 0", b_par_cnt, b_stop_cnt); end
        for (int n = 0; n < 5; n++) begin
            stop_err_frame();
            tick();
        end
        checks++; if (b_stop_cnt !== 2'd3) begin failures++; $display("FAIL sat: got %0d want 3", b_stop_cnt); end
        checks++; if (a_par_cnt !== 8'd0 || a_stop_cnt !== 8'd0) begin failures++; $display("FAIL sat_a: got p=%0d s=%0d want 0 0", a_par_cnt, a_stop_cnt); end
        stop_err_frame();
        checks++; if (b_stop_error !== 1'b1) begin failures++; $display("FAIL sat_6th: got %b want 1", b_stop_error); end
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checks++; if (b_stop_cnt !== 2'd0) begin failures++; $display("FAIL clr_wins: got %0d want 0", b_stop_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'hC3;
        stop_err_frame();
        tick();
        checks++; if (b_stop_cnt !== 2'd1 || b_data_out !== 8'hA3) begin failures++; $display("FAIL pre_rst: got cnt=%0d d=%h want 1 a3", b_stop_cnt, b_data_out); end
        start_frame(1'b1, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        Reset = 1'b1;
        bit_valid = 1'b1;
        sampled_bit = d[4];
        tick();
        Reset = 1'b0;
        bit_valid = 1'b0;
        sampled_bit = 1'b1;
        checks++; if (b_busy !== 1'b0 || b_data_out !== 8'h00) begin failures++; $display("FAIL mid_rst: got busy=%b d=%h want 0 00", b_busy, b_data_out); end
        checks++; if (b_stop_cnt !== 2'd0 || b_par_cnt !== 2'd0 || b_data_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_cnt: got s=%0d p=%0d v=%b want 0 0 0", b_stop_cnt, b_par_cnt, b_data_valid); end
        tick();
        send_bit(1'b0);
        start_frame(1'b1, 1'b0);
        send_bit(1'b0);
        send_data(8'h96);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        checks++; if (b_data_valid !== 1'b1 || b_data_out !== 8'h96 || b_parity_error !== 1'b0) begin failures++; $display("FAIL post_rst: got v=%b d=%h pe=%b want 1 96 0", b_data_valid, b_data_out, b_parity_error); end
        tick();
    endtask

    task automatic test_back_to_back();
        start_frame(1'b0, 1'b0);
        send_bit(1'b0);
        send_data(8'h12);
        send_bit(1'b1);
        send_bit(1'b1);
        checks++; if (b_data_valid !== 1'b1 || b_data_out !== 8'h12) begin failures++; $display("FAIL b2b_first: got v=%b d=%h want 1 12", b_data_valid, b_data_out); end
        tick();
        start_frame(1'b0, 1'b0);
        send_bit(1'b0);
        send_data(8'hED);
        checks++; if (b_data_out !== 8'h12 || b_busy !== 1'b1) begin failures++; $display("FAIL b2b_hold: got d=%h busy=%b want 12 1", b_data_out, b_busy); end
        send_bit(1'b1);
        send_bit(1'b1);
        checks++; if (b_data_valid !== 1'b1 || b_data_out !== 8'hED) begin failures++; $display("FAIL b2b_second: got v=%b d=%h want 1 ed", b_data_valid, b_data_out); end
        tick();
    endtask

    initial begin
        Reset = 1'b1;
        frame_start = 1'b0;
        bit_valid = 1'b0;
        sampled_bit = 1'b1;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        clr_cnt = 1'b0;
        test_reset();
        test_good_frame();
        test_parity_error();
        test_odd_parity();
        test_stop_error();
        test_start_error();
        test_saturation();
        test_reset_mid_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
